vframer: RTL and testbench

VFRAMER -- requirements
Module: vframer

---
 rtl/vframer.sv | 194 +++++++++++++++++++
 tb/tb_vframer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vframer.sv
// vframer: bit-serial frame synchroniser for a Viterbi decoder output stream.
// Hunts for SYNC_WORD, verifies LOCK_CNT consecutive frames, then emits payload
// bytes while locked. A missed sync is tolerated up to LOSS_CNT-1 frames in a row.
// Optional decoder error counter on err_count: define VFRAMER_ERRCNT_EN.
module vframer #(
    parameter logic [7:0]  SYNC_WORD     = 8'hA5,
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter int unsigned LOCK_CNT      = 2,
    parameter int unsigned LOSS_CNT      = 3
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       decoded,
    input  logic       error,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_count
);

    localparam int unsigned FRAME_BITS = (PAYLOAD_BYTES + 1) * 8;
    localparam int unsigned PAY_BITS   = PAYLOAD_BYTES * 8;
    localparam int unsigned POS_W      = 11;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned FILL_W     = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [7:0]          win, win_nx;
    logic [FILL_W-1:0]   fill, fill_nx;
    logic [POS_W-1:0]    pos, pos_nx;
    logic [CNT_W-1:0]    good, good_nx, good_inc;
    logic [CNT_W-1:0]    miss, miss_nx, miss_inc;
    logic                acc, acc_nx;

    logic [7:0]          shifted;
    logic                sync_hit;
    logic                frame_end;
    logic                byte_end;

    logic [7:0]          byte_out_nx;
    logic                byte_valid_nx;
    logic                byte_err_nx;
    logic                frame_start_nx;
    logic                locked_nx;

    // Window after shifting in the current bit, and frame position decodes
    assign shifted   = {win[6:0], decoded};
    assign sync_hit  = (shifted == SYNC_WORD);
    assign frame_end = (pos == POS_W'(FRAME_BITS - 1));
    assign byte_end  = (pos[2:0] == 3'd7) && (pos < POS_W'(PAY_BITS));
    assign good_inc  = good + CNT_W'(1);
    assign miss_inc  = miss + CNT_W'(1);

    // State register and framing datapath registers
    always_ff @(posedge Clock) begin
        if (reset) begin
            state <= HUNT;
            win   <= '0;
            fill  <= '0;
            pos   <= '0;
            good  <= '0;
            miss  <= '0;
            acc   <= 1'b0;
        end else begin
            state <= state_nx;
            win   <= win_nx;
            fill  <= fill_nx;
            pos   <= pos_nx;
            good  <= good_nx;
            miss  <= miss_nx;
            acc   <= acc_nx;
        end
    end

    // Next-state and counter update; everything holds when in_valid is low
    always_comb begin
        state_nx = state;
        win_nx   = win;
        fill_nx  = fill;
        pos_nx   = pos;
        good_nx  = good;
        miss_nx  = miss;
        acc_nx   = acc;
        if (in_valid) begin
            win_nx = shifted;
            case (state)
                HUNT: begin
                    fill_nx = (fill == FILL_W'(8)) ? fill : fill + FILL_W'(1);
                    if ((fill >= FILL_W'(7)) && sync_hit) begin
                        state_nx = VERIFY;
                        good_nx  = CNT_W'(1);
                        miss_nx  = '0;
                        pos_nx   = '0;
                        acc_nx   = 1'b0;
                    end
                end
                VERIFY, LOCKED: begin
                    pos_nx = frame_end ? '0 : pos + POS_W'(1);
                    acc_nx = (pos[2:0] == 3'd7) ? 1'b0 : (acc | error);
                    if (frame_end) begin
                        if (state == VERIFY) begin
                            if (sync_hit) begin
                                good_nx = good_inc;
                                if (good_inc >= CNT_W'(LOCK_CNT)) begin
                                    state_nx = LOCKED;
                                    miss_nx  = '0;
                                end
                            end else begin
                                state_nx = HUNT;
                                fill_nx  = '0;
                                good_nx  = '0;
                            end
                        end else begin
                            if (sync_hit) begin
                                miss_nx = '0;
                            end else if (miss_inc >= CNT_W'(LOSS_CNT)) begin
                                state_nx = HUNT;
                                fill_nx  = '0;
                                good_nx  = '0;
                                miss_nx  = '0;
                            end else begin
                                miss_nx = miss_inc;
                            end
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // Output decode: byte and frame strobes only while already locked
    always_comb begin
        byte_out_nx    = byte_out;
        byte_err_nx    = byte_err;
        byte_valid_nx  = 1'b0;
        frame_start_nx = 1'b0;
        locked_nx      = (state_nx == LOCKED);
        if (in_valid && (state == LOCKED)) begin
            if (byte_end) begin
                byte_valid_nx = 1'b1;
                byte_out_nx   = shifted;
                byte_err_nx   = acc | error;
            end
            if (frame_end && sync_hit) begin
                frame_start_nx = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge Clock) begin
        if (reset) begin
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            byte_err    <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            byte_out    <= byte_out_nx;
            byte_valid  <= byte_valid_nx;
            byte_err    <= byte_err_nx;
            frame_start <= frame_start_nx;
            locked      <= locked_nx;
        end
    end

`ifdef VFRAMER_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of errored valid bits, independent of framing state
    always_ff @(posedge Clock) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (in_valid && error && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_vframer.sv
// Testbench for vframer: frame-level vector table, hand-written corner sequences,
// and a randomized bit stream checked against a stream-indexed reference model.
module tb_vframer;

    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int PAY   = 4;
    localparam int FRAME = (PAY + 1) * 8;
    localparam int LOCKN = 2;
    localparam int LOSSN = 3;
    localparam int MAXB  = 2000;

    logic       Clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       decoded = 1'b0;
    logic       error = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_err;
    logic       frame_start;
    logic       locked;
    logic [7:0] err_count;

    vframer #(
        .SYNC_WORD    (SYNC),
        .PAYLOAD_BYTES(PAY),
        .LOCK_CNT     (LOCKN),
        .LOSS_CNT     (LOSSN)
    ) dut (
        .Clock      (Clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .decoded    (decoded),
        .error      (error),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .frame_start(frame_start),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0]  sync;
        logic [31:0] pay;
        int          err_bit;   // payload bit index (0 = first sent) carrying error, -1 none
        bit          exp_lk;
        int          exp_nb;
        int          exp_fs;
    } fvec_t;

    int checks = 0;
    int failures = 0;
    int fs_seen = 0;
    int err_total = 0;
    logic [8:0] obs[$];

    // Reference stream and per-valid-bit expectations
    int         nb;
    bit         sb[MAXB];
    bit         se[MAXB];
    bit         e_bv[MAXB];
    logic [7:0] e_bo[MAXB];
    bit         e_be[MAXB];
    bit         e_fs[MAXB];
    bit         e_lk[MAXB];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_errcnt(input int n);
`ifdef VFRAMER_ERRCNT_EN
        return (n > 255) ? 255 : n;
`else
        return (n < 0) ? n : 0;
`endif
    endfunction

    // Drive one cycle from a falling edge, then observe outputs at the next falling edge
    task automatic send_bit(input bit v, input bit b, input bit e);
        in_valid = v;
        decoded  = b;
        error    = e;
        @(negedge Clock);
        if (v && e) err_total++;
        if (byte_valid) obs.push_back({byte_err, byte_out});
        if (frame_start) fs_seen++;
        if (!v) begin
            check("idle_byte_valid", int'(byte_valid), 0);
            check("idle_frame_start", int'(frame_start), 0);
        end
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b1;
        decoded  = 1'b1;
        error    = 1'b1;
        repeat (n) @(negedge Clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        error    = 1'b0;
        obs.delete();
        fs_seen   = 0;
        err_total = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_out"}, int'(byte_out), 0);
        check({tag, "_byte_valid"}, int'(byte_valid), 0);
        check({tag, "_byte_err"}, int'(byte_err), 0);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_err_count"}, int'(err_count), 0);
    endtask

    // Send sync + payload MSB first; optionally an idle cycle after every bit
    task automatic apply_frame(input fvec_t fv, input bit gap, input string tag);
        int         nb0;
        int         fs0;
        logic [39:0] bits;
        logic [31:0] pw;
        nb0  = obs.size();
        fs0  = fs_seen;
        bits = {fv.sync, fv.pay};
        pw   = fv.pay;
        for (int i = 39; i >= 0; i--) begin
            send_bit(1'b1, bits[i], ((39 - i - 8) == fv.err_bit));
            if (gap) send_bit(1'b0, 1'($urandom), 1'($urandom));
        end
        check({tag, "_locked"}, int'(locked), int'(fv.exp_lk));
        check({tag, "_nbytes"}, obs.size() - nb0, fv.exp_nb);
        check({tag, "_frame_start"}, fs_seen - fs0, fv.exp_fs);
        if ((fv.exp_nb == PAY) && (obs.size() - nb0 == PAY)) begin
            for (int k = 0; k < PAY; k++) begin
                logic [8:0] got;
                logic [7:0] want;
                got  = obs[nb0 + k];
                want = pw[31 - 8*k -: 8];
                check($sformatf("%s_byte%0d", tag, k), int'(got[7:0]), int'(want));
                check($sformatf("%s_err%0d", tag, k), int'(got[8]),
                      int'(fv.err_bit >= 0 && (fv.err_bit / 8) == k));
            end
        end
    endtask

    function automatic logic [7:0] win_at(input int i);
        logic [7:0] w;
        w = '0;
        for (int k = 7; k >= 0; k--) begin
            w = {w[6:0], ((i - k) >= 0) ? sb[i - k] : 1'b0};
        end
        return w;
    endfunction

    // Reference: alignment tracked as the stream index of the last sync check
    task automatic run_model();
        int  mode;       // 0 hunt, 1 verify, 2 locked
        int  hunt_start;
        int  anchor;
        int  good;
        int  miss;
        int  off;
        logic [7:0] w;
        mode = 0; hunt_start = 0; anchor = 0; good = 0; miss = 0;
        for (int i = 0; i < nb; i++) begin
            w = win_at(i);
            e_bv[i] = 1'b0; e_bo[i] = '0; e_be[i] = 1'b0; e_fs[i] = 1'b0;
            if (mode == 0) begin
                if ((i - hunt_start + 1) >= 8 && w == SYNC) begin
                    mode = 1; good = 1; anchor = i;
                end
            end else begin
                off = i - anchor;
                if (mode == 2 && (off % 8) == 0 && off <= PAY * 8) begin
                    e_bv[i] = 1'b1;
                    e_bo[i] = w;
                    for (int k = 0; k < 8; k++) e_be[i] = e_be[i] | se[i - k];
                end
                if (off == FRAME) begin
                    anchor = i;
                    if (w == SYNC) begin
                        if (mode == 2) begin
                            miss = 0; e_fs[i] = 1'b1;
                        end else begin
                            good++;
                            if (good >= LOCKN) begin mode = 2; miss = 0; end
                        end
                    end else if (mode == 1) begin
                        mode = 0; hunt_start = i + 1;
                    end else begin
                        miss++;
                        if (miss >= LOSSN) begin mode = 0; hunt_start = i + 1; end
                    end
                end
            end
            e_lk[i] = (mode == 2);
        end
    endtask

    task automatic push_bit(input bit b);
        if (nb < MAXB) begin
            sb[nb] = b;
            se[nb] = ($urandom_range(0, 5) == 0);
            nb++;
        end
    endtask

    fvec_t tbl[11];

    initial begin
        int exp_ec;
        bit prev_lk;
        logic [7:0] s;
        logic [7:0] pb;
        int r;

        tbl[0]  = '{8'hA5, 32'h11223344, -1, 1'b0, 0, 0};
        tbl[1]  = '{8'hA5, 32'h11223344, -1, 1'b1, 4, 0};
        tbl[2]  = '{8'hA5, 32'h11223344, -1, 1'b1, 4, 1};
        tbl[3]  = '{8'hA5, 32'h11223344, 13, 1'b1, 4, 1};
        tbl[4]  = '{8'hA4, 32'h11223344, -1, 1'b1, 4, 0};
        tbl[5]  = '{8'hA4, 32'h11223344, -1, 1'b1, 4, 0};
        tbl[6]  = '{8'hA4, 32'h11223344, -1, 1'b0, 0, 0};
        tbl[7]  = '{8'hA5, 32'h11223344, -1, 1'b0, 0, 0};
        tbl[8]  = '{8'hA5, 32'h11223344, -1, 1'b1, 4, 0};
        tbl[9]  = '{8'hA5, 32'hA5A5A5A5, -1, 1'b1, 4, 1};
        tbl[10] = '{8'hA5, 32'h11223344, -1, 1'b1, 4, 1};

        @(negedge Clock);
        // Reset with in_valid and error high: outputs must stay cleared
        reset = 1'b1; in_valid = 1'b1; decoded = 1'b1; error = 1'b1;
        @(negedge Clock);
        check_all_zero("reset");
        do_reset(1);

        // Frame table, continuous in_valid
        for (int t = 0; t < 11; t++) apply_frame(tbl[t], 1'b0, $sformatf("tbl%0d", t));
        check("tbl_err_count", int'(err_count), exp_errcnt(err_total));

        // Same first frames with in_valid every second cycle
        do_reset(2);
        for (int t = 0; t < 4; t++) apply_frame(tbl[t], 1'b1, $sformatf("gap%0d", t));
        check("gap_err_count", int'(err_count), exp_errcnt(err_total));

        // Misaligned 5-bit prefix, then sync; payload equal to sync must not realign
        do_reset(1);
        begin
            logic [4:0] pre;
            pre = 5'b01101;
            for (int i = 4; i >= 0; i--) send_bit(1'b1, pre[i], 1'b0);
        end
        apply_frame(tbl[7], 1'b0, "pre0");
        apply_frame(tbl[8], 1'b0, "pre1");
        apply_frame(tbl[9], 1'b0, "pre2");
        apply_frame(tbl[10], 1'b0, "pre3");

        // Reset for one cycle mid-payload while locked
        begin
            logic [39:0] fb;
            fb = {8'hA5, 32'h11223344};
            for (int i = 39; i >= 20; i--) send_bit(1'b1, fb[i], 1'b0);
        end
        do_reset(1);
        check_all_zero("midrst");
        send_bit(1'b0, 1'b0, 1'b0);
        check("midrst_after_bv", int'(byte_valid), 0);
        apply_frame(tbl[7], 1'b0, "relock0");
        apply_frame(tbl[8], 1'b0, "relock1");

        // Randomized stream against the reference model
        do_reset(1);
        nb = 0;
        repeat ($urandom_range(0, 12)) push_bit(1'($urandom));
        while (nb < 1500) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) repeat ($urandom_range(1, 3)) push_bit(1'($urandom));
            s = SYNC;
            if (r < 3) s = s ^ 8'(1 << $urandom_range(0, 7));
            for (int i = 7; i >= 0; i--) push_bit(s[i]);
            for (int k = 0; k < PAY; k++) begin
                pb = (r == 5) ? SYNC : 8'($urandom);
                for (int i = 7; i >= 0; i--) push_bit(pb[i]);
            end
        end
        run_model();
        exp_ec  = 0;
        prev_lk = 1'b0;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 2)) begin
                send_bit(1'b0, 1'($urandom), 1'($urandom));
                check($sformatf("rnd_idle_lk[%0d]", i), int'(locked), int'(prev_lk));
            end
            send_bit(1'b1, sb[i], se[i]);
            if (se[i]) exp_ec++;
            check($sformatf("rnd_bv[%0d]", i), int'(byte_valid), int'(e_bv[i]));
            if (e_bv[i] && byte_valid) begin
                check($sformatf("rnd_bo[%0d]", i), int'(byte_out), int'(e_bo[i]));
                check($sformatf("rnd_be[%0d]", i), int'(byte_err), int'(e_be[i]));
            end
            check($sformatf("rnd_fs[%0d]", i), int'(frame_start), int'(e_fs[i]));
            check($sformatf("rnd_lk[%0d]", i), int'(locked), int'(e_lk[i]));
            check($sformatf("rnd_ec[%0d]", i), int'(err_count), exp_errcnt(exp_ec));
            prev_lk = e_lk[i];
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
